// File: rtl/button_event.sv
// Turns a debounced button level into one-shot press/release/long-press/repeat strobes plus a held level.
// All outputs registered; events appear on the sampling edge itself. No backpressure: strobes are fire-and-forget.
module button_event #(
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int CNT_W     = 10
) (
    input  logic clk_1KHz_i,
    input  logic rst_n_i,
    input  logic debounced_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_tick_o,
    output logic held_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_MS);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_MS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state_q;
    logic             d_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + ONE_C;

    always_ff @(posedge clk_1KHz_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            d_q           <= 1'b0;
            cnt_q         <= '0;
            press_o       <= 1'b0;
            release_o     <= 1'b0;
            long_press_o  <= 1'b0;
            repeat_tick_o <= 1'b0;
            held_o        <= 1'b0;
        end else begin
            d_q           <= debounced_i;
            press_o       <= 1'b0;
            release_o     <= 1'b0;
            long_press_o  <= 1'b0;
            repeat_tick_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (debounced_i && !d_q) begin
                        press_o <= 1'b1;
                        held_o  <= 1'b1;
                        cnt_q   <= ONE_C;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // Release is checked first so it always wins over a timer event.
                    if (!debounced_i) begin
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (cnt_q == LONG_C) begin
                        long_press_o <= 1'b1;
                        cnt_q        <= ONE_C;
                        state_q      <= REPEAT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                REPEAT: begin
                    if (!debounced_i) begin
                        release_o <= 1'b1;
                        held_o    <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (cnt_q == REPEAT_C) begin
                        repeat_tick_o <= 1'b1;
                        cnt_q         <= ONE_C;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Directed bench: expected events (kind, edge) are queued by stimulus and popped by per-DUT monitors.
module tb_button_event;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, deb, deb2;
    logic press1, rel1, long1, tick1, held1;
    logic press2, rel2, long2, tick2, held2;

    button_event #(.LONG_MS(5), .REPEAT_MS(3), .CNT_W(10)) dut1 (
        .clk_1KHz_i   (clk),
        .rst_n_i      (rst_n),
        .debounced_i  (deb),
        .press_o      (press1),
        .release_o    (rel1),
        .long_press_o (long1),
        .repeat_tick_o(tick1),
        .held_o       (held1)
    );

    button_event #(.LONG_MS(1), .REPEAT_MS(1), .CNT_W(10)) dut2 (
        .clk_1KHz_i   (clk),
        .rst_n_i      (rst_n),
        .debounced_i  (deb2),
        .press_o      (press2),
        .release_o    (rel2),
        .long_press_o (long2),
        .repeat_tick_o(tick2),
        .held_o       (held2)
    );

    localparam logic [3:0] EV_P = 4'b1000;
    localparam logic [3:0] EV_R = 4'b0100;
    localparam logic [3:0] EV_L = 4'b0010;
    localparam logic [3:0] EV_T = 4'b0001;

    typedef struct packed {
        int         edge_n;
        logic [3:0] ev;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        compared++;
        if (act != exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push1(input logic [3:0] ev, input int e);
        exp_t x;
        x.edge_n = e;
        x.ev     = ev;
        q1.push_back(x);
    endtask

    task automatic push2(input logic [3:0] ev, input int e);
        exp_t x;
        x.edge_n = e;
        x.ev     = ev;
        q2.push_back(x);
    endtask

    logic [3:0] ev1, ev2;
    exp_t       e1, e2;

    always @(negedge clk) begin
        if (rst_n) begin
            ev1 = {press1, rel1, long1, tick1};
            if (ev1 != 4'b0) begin
                if (q1.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL dut1_unexpected: got event %b at edge %0d, required none", ev1, cyc);
                end else begin
                    e1 = q1.pop_front();
                    chk("dut1_event_kind", int'(ev1), int'(e1.ev));
                    chk("dut1_event_edge", cyc, e1.edge_n);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            ev2 = {press2, rel2, long2, tick2};
            if (ev2 != 4'b0) begin
                if (q2.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL dut2_unexpected: got event %b at edge %0d, required none", ev2, cyc);
                end else begin
                    e2 = q2.pop_front();
                    chk("dut2_event_kind", int'(ev2), int'(e2.ev));
                    chk("dut2_event_edge", cyc, e2.edge_n);
                end
            end
        end
    end

    task automatic gap();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_press"}, int'(press1), 0);
        chk({tag, "_release"}, int'(rel1), 0);
        chk({tag, "_long"}, int'(long1), 0);
        chk({tag, "_tick"}, int'(tick1), 0);
        chk({tag, "_held"}, int'(held1), 0);
        chk({tag, "_held2"}, int'(held2), 0);
    endtask

    initial begin
        int e0;
        rst_n = 1'b0;
        deb   = 1'b0;
        deb2  = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gap();

        // Short press: 3 cycles high
        e0 = cyc + 1;
        push1(EV_P, e0);
        push1(EV_R, e0 + 3);
        deb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("short_held_high", int'(held1), 1);
        end
        deb = 1'b0;
        @(negedge clk);
        chk("short_held_low", int'(held1), 0);
        gap();

        // Long hold: 13 cycles high
        e0 = cyc + 1;
        push1(EV_P, e0);
        push1(EV_L, e0 + 5);
        push1(EV_T, e0 + 8);
        push1(EV_T, e0 + 11);
        push1(EV_R, e0 + 13);
        deb = 1'b1;
        repeat (13) @(negedge clk);
        deb = 1'b0;
        gap();

        // Collision in HOLD: first 0 sample on edge 5
        e0 = cyc + 1;
        push1(EV_P, e0);
        push1(EV_R, e0 + 5);
        deb = 1'b1;
        repeat (5) @(negedge clk);
        deb = 1'b0;
        gap();

        // Collision in REPEAT: first 0 sample on edge 8
        e0 = cyc + 1;
        push1(EV_P, e0);
        push1(EV_L, e0 + 5);
        push1(EV_R, e0 + 8);
        deb = 1'b1;
        repeat (8) @(negedge clk);
        deb = 1'b0;
        gap();

        // Reset between edges 6 and 7 while held, then re-press after reset
        e0 = cyc + 1;
        push1(EV_P, e0);
        push1(EV_L, e0 + 5);
        deb = 1'b1;
        repeat (7) @(negedge clk);
        chk("pre_reset_held", int'(held1), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midhold_reset");
        @(negedge clk);
        rst_n = 1'b1;
        push1(EV_P, e0 + 8);
        push1(EV_L, e0 + 13);
        push1(EV_R, e0 + 15);
        repeat (7) @(negedge clk);
        deb = 1'b0;
        gap();

        // Back-to-back 1,0,1,0
        e0 = cyc + 1;
        push1(EV_P, e0);
        push1(EV_R, e0 + 1);
        push1(EV_P, e0 + 2);
        push1(EV_R, e0 + 3);
        deb = 1'b1;
        @(negedge clk);
        deb = 1'b0;
        @(negedge clk);
        deb = 1'b1;
        @(negedge clk);
        deb = 1'b0;
        gap();

        // Boundary parameters on the second instance
        e0 = cyc + 1;
        push2(EV_P, e0);
        push2(EV_L, e0 + 1);
        push2(EV_T, e0 + 2);
        push2(EV_T, e0 + 3);
        push2(EV_R, e0 + 4);
        deb2 = 1'b1;
        repeat (4) @(negedge clk);
        deb2 = 1'b0;
        gap();
        gap();

        chk("dut1_pending_events", q1.size(), 0);
        chk("dut2_pending_events", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/button_event.md
# button_event

Converts the debounced level of one push-button into single-cycle user events: press, release, long-press and auto-repeat. It sits directly downstream of the button debouncer, in the same 1 kHz clock domain. It gives the VGA control logic (cursor/colour selection) clean one-shot strobes instead of a level. All timing is counted in clock cycles, which are milliseconds at 1 kHz.

## Interface
Parameters:
- LONG_MS, default 500: cycles a press must be held before long_press fires; legal range is 1 to 2^CNT_W-1.
- REPEAT_MS, default 100: cycles between repeat_tick pulses after long_press; legal range is 1 to 2^CNT_W-1.
- CNT_W, default 10: width of the internal hold counter.

Ports:
- clk_1KHz, input, 1: the single clock; all logic is on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- debounced, input, 1: stable button level from the debouncer; 1 means pressed.
- press, output, 1: one-cycle strobe on the rising edge of debounced.
- release, output, 1: one-cycle strobe on the falling edge of debounced.
- long_press, output, 1: one-cycle strobe once the button has been held LONG_MS cycles.
- repeat_tick, output, 1: one-cycle strobe every REPEAT_MS cycles after long_press while the button stays held.
- held, output, 1: level that is 1 from the press edge until the release edge, inclusive of the press cycle.

## Operation
- Internal state:
  - d_q: previous sample of debounced.
  - FSM with states IDLE, HOLD, REPEAT.
  - cnt: unsigned hold counter, CNT_W bits wide.
- All outputs are registered. press, release, long_press and repeat_tick default to 0 on every edge unless set as described below.
- In IDLE:
  - If debounced=1 and d_q=0, then on this edge press<=1, held<=1, cnt<=1, and the FSM moves to HOLD.
- In HOLD:
  - If debounced=0: release<=1, held<=0, cnt<=0, and the FSM moves to IDLE.
  - Else, if cnt==LONG_MS: long_press<=1, cnt<=1, and the FSM moves to REPEAT.
  - Else: cnt<=cnt+1.
- In REPEAT:
  - If debounced=0: release<=1, held<=0, cnt<=0, and the FSM moves to IDLE.
  - Else, if cnt==REPEAT_MS: repeat_tick<=1 and cnt<=1.
  - Else: cnt<=cnt+1.
- Release has priority. If debounced=0 on the same edge that would fire long_press or repeat_tick, only release fires.
- cnt never wraps, because it is reloaded at LONG_MS or REPEAT_MS, both of which are at most 2^CNT_W-1. Comparisons are unsigned at CNT_W bits.
- d_q<=debounced on every edge in every state.

## Timing
- Reset (rst_n=0, asynchronous):
  - press, release, long_press, repeat_tick and held are all 0.
  - d_q=0, cnt=0, FSM is in IDLE.
  - The block leaves reset on the first rising edge with rst_n=1.
  - If debounced is already 1 at that edge, press fires on that edge. This is intended: a button held through reset reports a press.
- Reset asserted mid-hold: all outputs clear immediately and no release strobe is generated.
- Latency from debounced changing:
  - Let edge k be the first rising edge that samples debounced=1.
  - press and held go high at edge k.
  - long_press fires at edge k+LONG_MS.
  - repeat_tick fires at edges k+LONG_MS+n*REPEAT_MS, for n≥1.
  - release fires at the first edge that samples debounced=0; held falls on that same edge.
- Minimum hold: a one-cycle high pulse on debounced gives press at edge k and release at edge k+1.
- Events are mutually exclusive: at most one of press, release, long_press and repeat_tick is high in any cycle.

## Test plan
All scenarios use LONG_MS=5, REPEAT_MS=3, CNT_W=10. In each, edge 0 is the first rising edge that samples debounced=1.

1. Short press: debounced is 1 for 3 cycles. Required: press at edge 0, release at edge 3, held=1 over edges 0–2, and no long_press.
2. Long hold: debounced is 1 for 13 cycles. Required: press at edge 0, long_press at edge 5, repeat_tick at edges 8 and 11, release at edge 13.
3. Collision: debounced falls so that the first sample of 0 lands on edge 5. Required: release at edge 5 with no long_press. Repeat the check with the first 0 sample on edge 8 in REPEAT: release at edge 8 with no repeat_tick.
4. Reset mid-hold: assert rst_n=0 between edges 6 and 7. Required: all outputs 0 immediately. After rst_n is released with debounced still 1, press fires on the first edge, followed by long_press 5 edges later.
5. Back-to-back presses: the pattern 1,0,1,0 on debounced, one cycle each. Required: press, release, press, release on four consecutive edges.
6. Boundary parameters LONG_MS=1, REPEAT_MS=1, hold for 4 cycles. Required: press at edge 0, long_press at edge 1, repeat_tick at edges 2 and 3, release at edge 4.
